// File: rtl/mux2_rr_arbiter.sv
// Packet-level round-robin arbiter in front of a shared 2:1 data-select path.
// Ownership is held until the owner's last beat, and beats pass through a one-entry output register.
module mux2_rr_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_last,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          sel_q, sel_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          can_load;
  logic          xfer0, xfer1;

  // The output slot can take a beat when it is empty or is draining this cycle.
  assign can_load   = !out_valid_q || out_ready;
  assign req0_ready = (state_q == GRANT0) && can_load;
  assign req1_ready = (state_q == GRANT1) && can_load;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not granted last time wins.
        if (req0_valid && (!req1_valid || last_grant_q)) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
          sel_d        = 1'b0;
        end else if (req1_valid) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
          sel_d        = 1'b1;
        end
      end
      GRANT0: if (xfer0 && req0_last) state_d = IDLE;
      GRANT1: if (xfer1 && req1_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (xfer0) begin
      out_valid_d = 1'b1;
      out_data_d  = req0_data;
      out_last_d  = req0_last;
    end else if (xfer1) begin
      out_valid_d = 1'b1;
      out_data_d  = req1_data;
      out_last_d  = req1_last;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Packet-level round-robin arbiter that shares the team's 2:1 data-select path between two valid/ready requesters. It decides which requester owns the path and drives the select. The grant is held until the owner's packet completes, marked by `last`. Selected beats are captured in a one-entry output register before the downstream consumer sees them.

## Interface
Parameters:
- `DW`, default 8, data width of each requester and the output.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req0_valid`  input  1  requester 0 has a beat.
- `req0_data`  input  DW  requester 0 beat data.
- `req0_last`  input  1  requester 0 beat is final beat of its packet.
- `req0_ready`  output  1  requester 0 beat accepted this cycle.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  DW  output beat data.
- `out_last`  output  1  output beat is final beat of its packet.
- `out_ready`  input  1  downstream accepts the output beat.
- `sel`  output  1  current mux select: 0 = requester 0, 1 = requester 1.
- `busy`  output  1  high while the FSM is in GRANT0 or GRANT1.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- Round-robin pointer `last_grant` (1 bit) stores the requester most recently granted.
- IDLE transitions:
  - Only req0_valid high: go to GRANT0.
  - Only req1_valid high: go to GRANT1.
  - Both high: grant the requester that is not `last_grant`.
  - Neither high: stay in IDLE.
  - On any grant, `last_grant` is updated to the granted index.
- GRANTn behaviour:
  - `sel` = n.
  - `reqn_ready` = !out_valid || out_ready.
  - The other requester's ready is 0.
  - In IDLE, both readies are 0.
- Beat transfer (`reqn_valid && reqn_ready`): load `out_data`/`out_last` from `reqn_data`/`reqn_last`, set `out_valid` = 1.
- Output drain: if `out_valid && out_ready` and no new load in the same cycle, clear `out_valid`.
- Packet end: a transfer with `reqn_last` = 1 moves GRANTn to IDLE on the same edge.
- Owner drops valid mid-packet: the grant is held indefinitely. There is no timeout and no preemption.
- `sel` is registered. It updates on entry to GRANT0/GRANT1 and holds its value in IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values (asynchronous assertion, synchronous release at the next edge):
  - state = IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `sel` = 0, `busy` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0.
  - `req0_ready` = 0, `req1_ready` = 0.
- Arbitration latency: requests seen in IDLE at edge k give GRANTn and `reqn_ready` in cycle k+1.
- Data latency: a beat accepted at edge k+1 appears on `out_data`/`out_valid` in cycle k+2. Input-to-output latency is one cycle.
- Throughput: one beat per cycle while `out_ready` stays high (simultaneous drain and load).
- Inter-packet gap: exactly one IDLE cycle after each packet's last beat is accepted, with both readies 0 during that cycle.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, `reqn_ready` = 0 and the output register holds its value.
- Single-beat packet (`valid` and `last` on the first beat): GRANTn lasts one cycle when unstalled.
- Reset mid-packet: the output beat is discarded and the FSM returns to IDLE. The requester must restart its packet.

## Test plan
- Reset check: assert `rst` with random inputs. Expect every output at its reset value, including `req0_ready` = `req1_ready` = 0 and `sel` = 0.
- Single requester: req0 sends a 3-beat packet AA, BB, CC with `last` on CC, `out_ready` held 1.
  - Cycle 1: `req0_ready` = 1.
  - `out_data` shows AA, BB, CC on cycles 2-4, with `out_last` = 1 only with CC.
  - `busy` drops after CC is accepted.
- Simultaneous first request: both valid at cycle 0 with 2-beat packets (0x11, 0x12 and 0x21, 0x22).
  - Output order is 0x11, 0x12, then one gap cycle, then 0x21, 0x22.
  - `sel` goes 0 → 1.
- Fairness: both requesters continuously send 1-beat packets for 8 packets. Grants alternate 0,1,0,1,… and no requester is served twice in a row.
- Backpressure: hold `out_ready` = 0 for 3 cycles mid-packet.
  - `out_data` holds its value and `req_ready` = 0 during the stall.
  - No beat is lost or duplicated; all 4 beats arrive in order after release.
- Reset mid-packet: assert `rst` after beat 2 of 4 from req1.
  - Outputs return to reset values immediately.
  - A subsequent req0 packet is granted first (`last_grant` = 1 after reset).
